// File: rtl/id_ex_stage_pkg.sv
// Shared pipeline constants and types for the ID/EX register and the forwarding unit.
package id_ex_stage_pkg;

  localparam int REG_AW = 3;
  localparam logic [REG_AW-1:0] REG_ZERO = 3'b000;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    BUBBLE = 2'b01,
    WAIT   = 2'b10
  } state_e;

  // Control bundle field order: {regWrite, memRead, memWrite}
  typedef struct packed {
    logic regWrite;
    logic memRead;
    logic memWrite;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Combinational load-use detect: EX holds a load whose rd feeds the ID instruction.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic              ex_valid_i,
  input  logic              ex_memRead_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_r1_i,
  input  logic [REG_AW-1:0] id_r2_i,
  input  logic              id_uses_r2_i,
  output logic              lu_o
);

  assign lu_o = ex_valid_i & ex_memRead_i & id_valid_i & (ex_rd_i != REG_ZERO) &
                ((ex_rd_i == id_r1_i) | (id_uses_r2_i & (ex_rd_i == id_r2_i)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch flush and data-memory wait.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_r1,
  input  logic [REG_AW-1:0] id_r2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_r2,
  input  logic              id_regWrite,
  input  logic              id_memRead,
  input  logic              id_memWrite,
  input  logic [DW-1:0]     id_opA,
  input  logic [DW-1:0]     id_opB,
  input  logic              flush,
  input  logic              mem_busy,
  output logic              stall_id,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_r1,
  output logic [REG_AW-1:0] ex_r2,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_regWrite,
  output logic              ex_memRead,
  output logic              ex_memWrite,
  output logic [DW-1:0]     ex_opA,
  output logic [DW-1:0]     ex_opB,
  output logic [CW-1:0]     stall_cnt
);

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic              valid_q, valid_d;
  logic [REG_AW-1:0] r1_q, r1_d, r2_q, r2_d, rd_q, rd_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [DW-1:0]     opa_q, opa_d, opb_q, opb_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              lu_s;
  logic              stall_s;

  id_ex_stage_hazard_detect u_hazard (
    .ex_valid_i   (valid_q),
    .ex_memRead_i (ctrl_q.memRead),
    .ex_rd_i      (rd_q),
    .id_valid_i   (id_valid),
    .id_r1_i      (id_r1),
    .id_r2_i      (id_r2),
    .id_uses_r2_i (id_uses_r2),
    .lu_o         (lu_s)
  );

  // The WAIT term keeps ID held through the edge on which mem_busy drops.
  assign stall_s = mem_busy | (lu_s & ~flush & (state_q != WAIT)) | (state_q == WAIT);

  // Next-state: hold on mem_busy, else flush > load-use bubble > normal load.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    if (mem_busy) begin
      state_d = WAIT;
      pend_d  = pend_q | flush;
    end else if (flush | pend_q | lu_s) begin
      valid_d = 1'b0;
      r1_d    = REG_ZERO;
      r2_d    = REG_ZERO;
      rd_d    = REG_ZERO;
      ctrl_d  = '0;
      opa_d   = '0;
      opb_d   = '0;
      pend_d  = 1'b0;
      state_d = (flush | pend_q) ? RUN : BUBBLE;
    end else begin
      valid_d = id_valid;
      r1_d    = id_r1;
      r2_d    = id_r2;
      rd_d    = id_rd;
      ctrl_d  = '{regWrite: id_regWrite, memRead: id_memRead, memWrite: id_memWrite};
      opa_d   = id_opA;
      opb_d   = id_opB;
      state_d = RUN;
    end
    if (stall_s && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      r1_q    <= REG_ZERO;
      r2_q    <= REG_ZERO;
      rd_q    <= REG_ZERO;
      ctrl_q  <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_id    = stall_s;
  assign ex_valid    = valid_q;
  assign ex_r1       = r1_q;
  assign ex_r2       = r2_q;
  assign ex_rd       = rd_q;
  assign ex_regWrite = ctrl_q.regWrite;
  assign ex_memRead  = ctrl_q.memRead;
  assign ex_memWrite = ctrl_q.memWrite;
  assign ex_opA      = opa_q;
  assign ex_opB      = opb_q;
  assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; a CW=4 instance shares the stimulus for saturation.
module tb_id_ex_stage;

  logic        clk, rst_n;
  logic        id_valid, id_uses_r2, id_regWrite, id_memRead, id_memWrite;
  logic [2:0]  id_r1, id_r2, id_rd;
  logic [15:0] id_opA, id_opB;
  logic        flush, mem_busy;

  logic        stall_id, ex_valid, ex_regWrite, ex_memRead, ex_memWrite;
  logic [2:0]  ex_r1, ex_r2, ex_rd;
  logic [15:0] ex_opA, ex_opB, stall_cnt;

  logic        stall_id4, ex_valid4, ex_regWrite4, ex_memRead4, ex_memWrite4;
  logic [2:0]  ex_r14, ex_r24, ex_rd4;
  logic [15:0] ex_opA4, ex_opB4;
  logic [3:0]  stall_cnt4;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;

  id_ex_stage #(.DW(16), .CW(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_r1(id_r1), .id_r2(id_r2),
    .id_rd(id_rd), .id_uses_r2(id_uses_r2), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite), .id_opA(id_opA), .id_opB(id_opB),
    .flush(flush), .mem_busy(mem_busy), .stall_id(stall_id), .ex_valid(ex_valid),
    .ex_r1(ex_r1), .ex_r2(ex_r2), .ex_rd(ex_rd), .ex_regWrite(ex_regWrite),
    .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite), .ex_opA(ex_opA), .ex_opB(ex_opB),
    .stall_cnt(stall_cnt)
  );

  id_ex_stage #(.DW(16), .CW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_r1(id_r1), .id_r2(id_r2),
    .id_rd(id_rd), .id_uses_r2(id_uses_r2), .id_regWrite(id_regWrite),
    .id_memRead(id_memRead), .id_memWrite(id_memWrite), .id_opA(id_opA), .id_opB(id_opB),
    .flush(flush), .mem_busy(mem_busy), .stall_id(stall_id4), .ex_valid(ex_valid4),
    .ex_r1(ex_r14), .ex_r2(ex_r24), .ex_rd(ex_rd4), .ex_regWrite(ex_regWrite4),
    .ex_memRead(ex_memRead4), .ex_memWrite(ex_memWrite4), .ex_opA(ex_opA4), .ex_opB(ex_opB4),
    .stall_cnt(stall_cnt4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [2:0] r1, input logic [2:0] r2,
                        input logic [2:0] rd, input logic u2, input logic rw,
                        input logic mr, input logic [15:0] a, input logic [15:0] b);
    id_valid = v; id_r1 = r1; id_r2 = r2; id_rd = rd; id_uses_r2 = u2;
    id_regWrite = rw; id_memRead = mr; id_memWrite = 1'b0; id_opA = a; id_opB = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; mem_busy = 1'b0;
    set_id(1'b1, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h5678);
    tick(); tick();
    total++; if (ex_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
    total++; if (ex_rd !== 3'd0 || ex_opA !== 16'h0 || ex_regWrite !== 1'b0)
      begin bad++; $display("FAIL reset_fields rd=%0d opA=%h rw=%b exp 0", ex_rd, ex_opA, ex_regWrite); end
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_id); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", stall_cnt); end
    rst_n = 1'b1;
    tick();
    total++; if (ex_valid !== 1'b1 || ex_rd !== 3'd3 || ex_opA !== 16'h1234 || ex_opB !== 16'h5678)
      begin bad++; $display("FAIL reset_release v=%b rd=%0d opA=%h opB=%h exp v=1 rd=3 opA=1234 opB=5678", ex_valid, ex_rd, ex_opA, ex_opB); end
  endtask

  task automatic test_load_use();
    set_id(1'b1, 3'd1, 3'd0, 3'd2, 1'b0, 1'b1, 1'b1, 16'h0011, 16'h0022);
    tick();
    set_id(1'b1, 3'd2, 3'd4, 3'd6, 1'b1, 1'b1, 1'b0, 16'hAAAA, 16'hBBBB);
    #1;
    total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", stall_id); end
    tick(); exp_cnt++;
    total++; if (ex_valid !== 1'b0 || ex_rd !== 3'd0 || ex_memRead !== 1'b0)
      begin bad++; $display("FAIL lu_bubble v=%b rd=%0d mr=%b exp all 0", ex_valid, ex_rd, ex_memRead); end
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL lu_stall_once got=%b exp=0", stall_id); end
    tick();
    total++; if (ex_valid !== 1'b1 || ex_rd !== 3'd6 || ex_opA !== 16'hAAAA)
      begin bad++; $display("FAIL lu_release v=%b rd=%0d opA=%h exp v=1 rd=6 opA=aaaa", ex_valid, ex_rd, ex_opA); end
    total++; if (stall_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
    // Load to r0 never creates a hazard.
    set_id(1'b1, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 16'h0001, 16'h0002);
    tick();
    set_id(1'b1, 3'd0, 3'd0, 3'd5, 1'b1, 1'b1, 1'b0, 16'h0C0C, 16'h0D0D);
    #1;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL lu_r0_stall got=%b exp=0", stall_id); end
    tick();
    total++; if (ex_valid !== 1'b1 || ex_rd !== 3'd5 || ex_opA !== 16'h0C0C)
      begin bad++; $display("FAIL lu_r0_load v=%b rd=%0d opA=%h exp v=1 rd=5 opA=0c0c", ex_valid, ex_rd, ex_opA); end
  endtask

  task automatic test_uses_r2();
    set_id(1'b1, 3'd1, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h0000);
    tick();
    set_id(1'b1, 3'd1, 3'd5, 3'd7, 1'b0, 1'b1, 1'b0, 16'h7777, 16'h0000);
    #1;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL r2_gated_stall got=%b exp=0", stall_id); end
    tick();
    total++; if (ex_valid !== 1'b1 || ex_rd !== 3'd7) begin bad++; $display("FAIL r2_gated_load v=%b rd=%0d exp v=1 rd=7", ex_valid, ex_rd); end
    set_id(1'b1, 3'd1, 3'd0, 3'd5, 1'b0, 1'b1, 1'b1, 16'h0005, 16'h0000);
    tick();
    set_id(1'b1, 3'd1, 3'd5, 3'd7, 1'b1, 1'b1, 1'b0, 16'h7778, 16'h0000);
    #1;
    total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL r2_used_stall got=%b exp=1", stall_id); end
    tick(); exp_cnt++;
    total++; if (ex_valid !== 1'b0 || stall_id !== 1'b0)
      begin bad++; $display("FAIL r2_used_bubble v=%b stall=%b exp 0 0", ex_valid, stall_id); end
    tick();
    total++; if (ex_rd !== 3'd7 || ex_opA !== 16'h7778) begin bad++; $display("FAIL r2_used_load rd=%0d opA=%h exp rd=7 opA=7778", ex_rd, ex_opA); end
  endtask

  task automatic test_flush_lu();
    set_id(1'b1, 3'd1, 3'd0, 3'd2, 1'b0, 1'b1, 1'b1, 16'h0002, 16'h0000);
    tick();
    set_id(1'b1, 3'd2, 3'd0, 3'd3, 1'b0, 1'b1, 1'b0, 16'h3333, 16'h0000);
    flush = 1'b1;
    #1;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL flush_lu_stall got=%b exp=0", stall_id); end
    tick();
    flush = 1'b0;
    total++; if (ex_valid !== 1'b0 || ex_rd !== 3'd0 || ex_opA !== 16'h0)
      begin bad++; $display("FAIL flush_lu_bubble v=%b rd=%0d opA=%h exp all 0", ex_valid, ex_rd, ex_opA); end
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL flush_lu_after got=%b exp=0", stall_id); end
    tick();
    total++; if (ex_valid !== 1'b1 || ex_rd !== 3'd3) begin bad++; $display("FAIL flush_lu_next v=%b rd=%0d exp v=1 rd=3", ex_valid, ex_rd); end
    total++; if (stall_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL flush_lu_cnt got=%0d exp=%0d", stall_cnt, exp_cnt); end
  endtask

  task automatic test_mem_wait();
    set_id(1'b1, 3'd1, 3'd2, 3'd4, 1'b1, 1'b1, 1'b0, 16'h5555, 16'h6666);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL wait_stall cyc=%0d got=%b exp=1", i, stall_id); end
      tick(); exp_cnt++;
      total++; if (ex_rd !== 3'd3 || ex_opA !== 16'h3333)
        begin bad++; $display("FAIL wait_frozen cyc=%0d rd=%0d opA=%h exp rd=3 opA=3333", i, ex_rd, ex_opA); end
    end
    // Stall is still held on the edge where mem_busy has fallen.
    mem_busy = 1'b0;
    #1;
    total++; if (stall_id !== 1'b1) begin bad++; $display("FAIL wait_release_stall got=%b exp=1", stall_id); end
    tick(); exp_cnt++;
    total++; if (ex_valid !== 1'b1 || ex_rd !== 3'd4 || ex_opA !== 16'h5555 || ex_opB !== 16'h6666)
      begin bad++; $display("FAIL wait_release_load v=%b rd=%0d opA=%h opB=%h exp v=1 rd=4 opA=5555 opB=6666", ex_valid, ex_rd, ex_opA, ex_opB); end
    total++; if (stall_id !== 1'b0 || stall_cnt !== 16'(exp_cnt))
      begin bad++; $display("FAIL wait_cnt stall=%b cnt=%0d exp stall=0 cnt=%0d", stall_id, stall_cnt, exp_cnt); end
    // Flush during the second busy cycle becomes a bubble after the wait.
    set_id(1'b1, 3'd1, 3'd2, 3'd6, 1'b1, 1'b1, 1'b0, 16'h9999, 16'h0000);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flush = (i == 1);
      tick(); exp_cnt++;
    end
    flush = 1'b0;
    mem_busy = 1'b0;
    total++; if (ex_rd !== 3'd4 || ex_valid !== 1'b1) begin bad++; $display("FAIL pend_frozen rd=%0d v=%b exp rd=4 v=1", ex_rd, ex_valid); end
    tick(); exp_cnt++;
    total++; if (ex_valid !== 1'b0 || ex_rd !== 3'd0 || ex_opA !== 16'h0)
      begin bad++; $display("FAIL pend_flush_bubble v=%b rd=%0d opA=%h exp all 0", ex_valid, ex_rd, ex_opA); end
    tick();
    total++; if (ex_valid !== 1'b1 || ex_rd !== 3'd6 || ex_opA !== 16'h9999)
      begin bad++; $display("FAIL pend_flush_next v=%b rd=%0d opA=%h exp v=1 rd=6 opA=9999", ex_valid, ex_rd, ex_opA); end
    total++; if (stall_cnt !== 16'(exp_cnt) || stall_cnt4 !== 4'(exp_cnt))
      begin bad++; $display("FAIL pend_cnt cnt=%0d cnt4=%0d exp=%0d", stall_cnt, stall_cnt4, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    set_id(1'b1, 3'd1, 3'd2, 3'd1, 1'b1, 1'b1, 1'b0, 16'h0101, 16'h1010);
    tick();
    total++; if (ex_rd !== 3'd1 || ex_opA !== 16'h0101) begin bad++; $display("FAIL b2b_0 rd=%0d opA=%h exp rd=1 opA=0101", ex_rd, ex_opA); end
    set_id(1'b1, 3'd3, 3'd4, 3'd2, 1'b1, 1'b0, 1'b0, 16'h0202, 16'h2020);
    id_memWrite = 1'b1;
    tick();
    total++; if (ex_rd !== 3'd2 || ex_memWrite !== 1'b1 || ex_regWrite !== 1'b0 || ex_r1 !== 3'd3 || ex_r2 !== 3'd4)
      begin bad++; $display("FAIL b2b_1 rd=%0d mw=%b rw=%b r1=%0d r2=%0d exp 2 1 0 3 4", ex_rd, ex_memWrite, ex_regWrite, ex_r1, ex_r2); end
    set_id(1'b0, 3'd5, 3'd6, 3'd7, 1'b0, 1'b1, 1'b0, 16'h0303, 16'h3030);
    tick();
    total++; if (ex_valid !== 1'b0 || ex_rd !== 3'd7 || ex_opB !== 16'h3030)
      begin bad++; $display("FAIL b2b_2 v=%b rd=%0d opB=%h exp v=0 rd=7 opB=3030", ex_valid, ex_rd, ex_opB); end
  endtask

  task automatic test_saturation();
    mem_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(); exp_cnt++;
    end
    total++; if (stall_cnt4 !== 4'd15) begin bad++; $display("FAIL sat_cnt4 got=%0d exp=15", stall_cnt4); end
    total++; if (stall_cnt !== 16'(exp_cnt)) begin bad++; $display("FAIL sat_cnt16 got=%0d exp=%0d", stall_cnt, exp_cnt); end
    mem_busy = 1'b0;
    tick();
    total++; if (stall_cnt4 !== 4'd15) begin bad++; $display("FAIL sat_hold got=%0d exp=15", stall_cnt4); end
  endtask

  task automatic test_reset_mid_stall();
    set_id(1'b1, 3'd1, 3'd2, 3'd5, 1'b1, 1'b1, 1'b0, 16'h4444, 16'h0000);
    mem_busy = 1'b1; flush = 1'b1;
    tick(); tick();
    flush = 1'b0;
    rst_n = 1'b0;
    tick();
    mem_busy = 1'b0;
    #1;
    total++; if (ex_valid !== 1'b0 || ex_rd !== 3'd0 || stall_cnt !== 16'd0 || stall_cnt4 !== 4'd0)
      begin bad++; $display("FAIL rst_mid_regs v=%b rd=%0d cnt=%0d cnt4=%0d exp all 0", ex_valid, ex_rd, stall_cnt, stall_cnt4); end
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL rst_mid_stall got=%b exp=0", stall_id); end
    rst_n = 1'b1;
    tick();
    total++; if (ex_valid !== 1'b1 || ex_rd !== 3'd5 || ex_opA !== 16'h4444)
      begin bad++; $display("FAIL rst_mid_load v=%b rd=%0d opA=%h exp v=1 rd=5 opA=4444", ex_valid, ex_rd, ex_opA); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_uses_r2();
    test_flush_lu();
    test_mem_wait();
    test_back_to_back();
    test_saturation();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
